// File: rtl/b_id_ex_alu_issue.sv
// ID/EX issue stage: decodes a MIPS instruction into the ALU execution interface
// and holds it in the pipeline register, with stall, flush and bubble insertion.
module b_id_ex_alu_issue (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_b_idex_valid,
  input  logic        i_b_idex_stall,
  input  logic        i_b_idex_flush,
  input  logic [31:0] i_b_idex_instr,
  input  logic [31:0] i_b_idex_rs_data,
  input  logic [31:0] i_b_idex_rt_data,
  output logic        o_b_idex_valid,
  output logic [3:0]  o_b_idex_alu_ctrl,
  output logic [31:0] o_b_idex_operand_1,
  output logic [31:0] o_b_idex_operand_2,
  output logic [4:0]  o_b_idex_shamt,
  output logic [4:0]  o_b_idex_dest,
  output logic        o_b_idex_reg_write,
  output logic        o_b_idex_mem_read,
  output logic        o_b_idex_mem_write,
  output logic        o_b_idex_branch_eq,
  output logic        o_b_idex_branch_ne,
  output logic [31:0] o_b_idex_rt_data,
  output logic        o_b_idex_illegal
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SRL = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_LUI = 4'b1111;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch_eq;
    logic        branch_ne;
    logic [31:0] rt_data;
  } idex_t;

  localparam idex_t BUBBLE = '0;

  idex_t idex_q, idex_d, dec;
  logic  illegal_q, illegal_d;
  logic  legal;

  logic [5:0]  opcode, funct;
  logic [4:0]  rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext;
  logic        unused_rs;

  assign opcode    = i_b_idex_instr[31:26];
  assign rt        = i_b_idex_instr[20:16];
  assign rd        = i_b_idex_instr[15:11];
  assign shamt     = i_b_idex_instr[10:6];
  assign funct     = i_b_idex_instr[5:0];
  assign imm       = i_b_idex_instr[15:0];
  assign imm_sext  = {{16{imm[15]}}, imm};
  assign imm_zext  = {16'h0000, imm};
  // rs only selects the register-file read, which arrives as i_b_idex_rs_data
  assign unused_rs = ^i_b_idex_instr[25:21];

  always_comb begin
    dec         = BUBBLE;
    legal       = 1'b1;
    dec.valid   = 1'b1;
    dec.op1     = i_b_idex_rs_data;
    dec.rt_data = i_b_idex_rt_data;
    dec.dest    = rt;
    dec.reg_write = 1'b1;
    case (opcode)
      6'h00: begin
        dec.op2  = i_b_idex_rt_data;
        dec.dest = rd;
        case (funct)
          6'h20, 6'h21: dec.alu_ctrl = ALU_ADD;
          6'h22, 6'h23: dec.alu_ctrl = ALU_SUB;
          6'h24:        dec.alu_ctrl = ALU_AND;
          6'h25:        dec.alu_ctrl = ALU_OR;
          6'h26:        dec.alu_ctrl = ALU_XOR;
          6'h27:        dec.alu_ctrl = ALU_NOR;
          6'h2A:        dec.alu_ctrl = ALU_SLT;
          6'h00: begin
            dec.alu_ctrl = ALU_SLL;
            dec.shamt    = shamt;
          end
          6'h02: begin
            dec.alu_ctrl = ALU_SRL;
            dec.shamt    = shamt;
          end
          default: legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec.alu_ctrl = ALU_ADD; dec.op2 = imm_sext; end
      6'h0A:        begin dec.alu_ctrl = ALU_SLT; dec.op2 = imm_sext; end
      6'h0C:        begin dec.alu_ctrl = ALU_AND; dec.op2 = imm_zext; end
      6'h0D:        begin dec.alu_ctrl = ALU_OR;  dec.op2 = imm_zext; end
      6'h0E:        begin dec.alu_ctrl = ALU_XOR; dec.op2 = imm_zext; end
      6'h0F:        begin dec.alu_ctrl = ALU_LUI; dec.op2 = imm_zext; end
      6'h23: begin
        dec.alu_ctrl = ALU_ADD;
        dec.op2      = imm_sext;
        dec.mem_read = 1'b1;
      end
      6'h2B: begin
        dec.alu_ctrl  = ALU_ADD;
        dec.op2       = imm_sext;
        dec.mem_write = 1'b1;
        dec.reg_write = 1'b0;
        dec.dest      = 5'd0;
      end
      6'h04, 6'h05: begin
        dec.alu_ctrl  = ALU_SUB;
        dec.op2       = i_b_idex_rt_data;
        dec.branch_eq = (opcode == 6'h04);
        dec.branch_ne = (opcode == 6'h05);
        dec.reg_write = 1'b0;
        dec.dest      = 5'd0;
      end
      default: legal = 1'b0;
    endcase
    // writes to $0 never reach the register file
    if (dec.dest == 5'd0) dec.reg_write = 1'b0;
  end

  always_comb begin
    idex_d    = BUBBLE;
    illegal_d = 1'b0;
    if (i_b_idex_flush) begin
      idex_d = BUBBLE;
    end else if (i_b_idex_stall) begin
      idex_d = idex_q;
    end else if (i_b_idex_valid) begin
      if (legal) idex_d = dec;
      else       illegal_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idex_q    <= BUBBLE;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_b_idex_valid     = idex_q.valid;
  assign o_b_idex_alu_ctrl  = idex_q.alu_ctrl;
  assign o_b_idex_operand_1 = idex_q.op1;
  assign o_b_idex_operand_2 = idex_q.op2;
  assign o_b_idex_shamt     = idex_q.shamt;
  assign o_b_idex_dest      = idex_q.dest;
  assign o_b_idex_reg_write = idex_q.reg_write;
  assign o_b_idex_mem_read  = idex_q.mem_read;
  assign o_b_idex_mem_write = idex_q.mem_write;
  assign o_b_idex_branch_eq = idex_q.branch_eq;
  assign o_b_idex_branch_ne = idex_q.branch_ne;
  assign o_b_idex_rt_data   = idex_q.rt_data;
  assign o_b_idex_illegal   = illegal_q;

endmodule

// File: tb/tb_b_id_ex_alu_issue.sv
// Self-checking bench for b_id_ex_alu_issue: expected register contents are queued
// as each cycle is driven and compared one cycle later against the DUT outputs.
module tb_b_id_ex_alu_issue;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_stall, i_flush;
  logic [31:0] i_instr, i_rs, i_rt;
  logic        o_valid, o_rw, o_mr, o_mw, o_beq, o_bne, o_illegal;
  logic [3:0]  o_ctrl;
  logic [31:0] o_op1, o_op2, o_rtd;
  logic [4:0]  o_shamt, o_dest;

  typedef struct packed {
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        rw, mr, mw, beq, bne;
    logic [31:0] rtd;
    logic        illegal;
  } exp_t;

  exp_t obs, got, want, last;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 i_clk = ~i_clk;

  b_id_ex_alu_issue dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_b_idex_valid(i_valid), .i_b_idex_stall(i_stall), .i_b_idex_flush(i_flush),
    .i_b_idex_instr(i_instr), .i_b_idex_rs_data(i_rs), .i_b_idex_rt_data(i_rt),
    .o_b_idex_valid(o_valid), .o_b_idex_alu_ctrl(o_ctrl),
    .o_b_idex_operand_1(o_op1), .o_b_idex_operand_2(o_op2),
    .o_b_idex_shamt(o_shamt), .o_b_idex_dest(o_dest),
    .o_b_idex_reg_write(o_rw), .o_b_idex_mem_read(o_mr), .o_b_idex_mem_write(o_mw),
    .o_b_idex_branch_eq(o_beq), .o_b_idex_branch_ne(o_bne),
    .o_b_idex_rt_data(o_rtd), .o_b_idex_illegal(o_illegal)
  );

  assign obs = {o_valid, o_ctrl, o_op1, o_op2, o_shamt, o_dest,
                o_rw, o_mr, o_mw, o_beq, o_bne, o_rtd, o_illegal};

  function automatic exp_t bub(input logic ill);
    bub = '0;
    bub.illegal = ill;
  endfunction

  function automatic exp_t ins(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input logic [4:0] d, input logic rw,
                               input logic mr, input logic mw, input logic be, input logic bn,
                               input logic [31:0] rtd);
    ins = '0;
    ins.valid = 1'b1; ins.ctrl = c; ins.op1 = a; ins.op2 = b; ins.shamt = sh; ins.dest = d;
    ins.rw = rw; ins.mr = mr; ins.mw = mw; ins.beq = be; ins.bne = bn; ins.rtd = rtd;
  endfunction

  // drive one cycle of inputs, queue its expectation, and land 1 ns after the edge
  task automatic step(input logic rst, input logic v, input logic st, input logic fl,
                      input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                      input exp_t e);
    @(negedge i_clk);
    i_rst = rst; i_valid = v; i_stall = st; i_flush = fl;
    i_instr = instr; i_rs = rs; i_rt = rt;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 0, 32'h00221820, 32'd1, 32'd2, bub(0));
      got = obs; want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset[%0d]: got %h expected %h", i, got, want); end
    end
    step(0, 1, 0, 0, 32'h00221820, 32'd1, 32'd2, ins(4'h0, 1, 2, 0, 3, 1, 0, 0, 0, 0, 2));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_first_load: got %h expected %h", got, want); end
  endtask

  task automatic test_rtype;
    logic [31:0] instr [10];
    exp_t        e     [10];
    instr[0] = 32'h00221822; e[0] = ins(4'h2, 32'h10, 32'h3, 0, 3, 1, 0, 0, 0, 0, 32'h3);
    instr[1] = 32'h00221824; e[1] = ins(4'h4, 32'h10, 32'h3, 0, 3, 1, 0, 0, 0, 0, 32'h3);
    instr[2] = 32'h00221825; e[2] = ins(4'h5, 32'h10, 32'h3, 0, 3, 1, 0, 0, 0, 0, 32'h3);
    instr[3] = 32'h00221826; e[3] = ins(4'h6, 32'h10, 32'h3, 0, 3, 1, 0, 0, 0, 0, 32'h3);
    instr[4] = 32'h00221827; e[4] = ins(4'h7, 32'h10, 32'h3, 0, 3, 1, 0, 0, 0, 0, 32'h3);
    instr[5] = 32'h0022182A; e[5] = ins(4'hA, 32'h10, 32'h3, 0, 3, 1, 0, 0, 0, 0, 32'h3);
    instr[6] = 32'h00221821; e[6] = ins(4'h0, 32'h10, 32'h3, 0, 3, 1, 0, 0, 0, 0, 32'h3);
    instr[7] = 32'h00221823; e[7] = ins(4'h2, 32'h10, 32'h3, 0, 3, 1, 0, 0, 0, 0, 32'h3);
    // add $0,$1,$2 : write to $0 suppressed
    instr[8] = 32'h00220020; e[8] = ins(4'h0, 32'h10, 32'h3, 0, 0, 0, 0, 0, 0, 0, 32'h3);
    // nonzero shamt field on a non-shift op is not passed through
    instr[9] = 32'h002218A0; e[9] = ins(4'h0, 32'h10, 32'h3, 0, 3, 1, 0, 0, 0, 0, 32'h3);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, instr[i], 32'h10, 32'h3, e[i]);
      got = obs; want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL rtype[%0d]: got %h expected %h", i, got, want); end
    end
    step(0, 1, 0, 0, 32'h00022080, 32'h0, 32'h2, ins(4'h1, 0, 2, 2, 4, 1, 0, 0, 0, 0, 2));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL sll: got %h expected %h", got, want); end
    step(0, 1, 0, 0, 32'h00022082, 32'h0, 32'h80, ins(4'h3, 0, 32'h80, 2, 4, 1, 0, 0, 0, 0, 32'h80));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL srl: got %h expected %h", got, want); end
  endtask

  task automatic test_itype;
    logic [31:0] instr [11];
    exp_t        e     [11];
    instr[0]  = 32'h3C05FFFF; e[0]  = ins(4'hF, 32'h7, 32'h0000FFFF, 0, 5, 1, 0, 0, 0, 0, 32'h9);
    instr[1]  = 32'h2026FFFF; e[1]  = ins(4'h0, 32'h7, 32'hFFFFFFFF, 0, 6, 1, 0, 0, 0, 0, 32'h9);
    instr[2]  = 32'h3026FFFF; e[2]  = ins(4'h4, 32'h7, 32'h0000FFFF, 0, 6, 1, 0, 0, 0, 0, 32'h9);
    instr[3]  = 32'h342600F0; e[3]  = ins(4'h5, 32'h7, 32'h000000F0, 0, 6, 1, 0, 0, 0, 0, 32'h9);
    instr[4]  = 32'h38268000; e[4]  = ins(4'h6, 32'h7, 32'h00008000, 0, 6, 1, 0, 0, 0, 0, 32'h9);
    instr[5]  = 32'h28268000; e[5]  = ins(4'hA, 32'h7, 32'hFFFF8000, 0, 6, 1, 0, 0, 0, 0, 32'h9);
    instr[6]  = 32'h2426FFFE; e[6]  = ins(4'h0, 32'h7, 32'hFFFFFFFE, 0, 6, 1, 0, 0, 0, 0, 32'h9);
    instr[7]  = 32'h8C260004; e[7]  = ins(4'h0, 32'h7, 32'h00000004, 0, 6, 1, 1, 0, 0, 0, 32'h9);
    instr[8]  = 32'hAC260008; e[8]  = ins(4'h0, 32'h7, 32'h00000008, 0, 0, 0, 0, 1, 0, 0, 32'h9);
    instr[9]  = 32'h10220005; e[9]  = ins(4'h2, 32'h7, 32'h00000009, 0, 0, 0, 0, 0, 1, 0, 32'h9);
    instr[10] = 32'h14220005; e[10] = ins(4'h2, 32'h7, 32'h00000009, 0, 0, 0, 0, 0, 0, 1, 32'h9);
    for (int i = 0; i < 11; i++) begin
      step(0, 1, 0, 0, instr[i], 32'h7, 32'h9, e[i]);
      got = obs; want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL itype[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  task automatic test_stall;
    last = ins(4'h2, 32'h5, 32'h1, 0, 3, 1, 0, 0, 0, 0, 32'h1);
    step(0, 1, 0, 0, 32'h00221822, 32'h5, 32'h1, last);
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL stall_load: got %h expected %h", got, want); end
    for (int i = 0; i < 3; i++) begin
      // different instruction and data, including an illegal one, must be ignored
      step(0, 1, 1, 0, (i == 2) ? 32'h00221818 : 32'h3C05FFFF, 32'hAA, 32'hBB, last);
      got = obs; want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  task automatic test_flush;
    step(0, 1, 0, 0, 32'h00221820, 32'h1, 32'h2, ins(4'h0, 1, 2, 0, 3, 1, 0, 0, 0, 0, 2));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL flush_load: got %h expected %h", got, want); end
    step(0, 1, 1, 1, 32'h00221820, 32'h1, 32'h2, bub(0));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL flush_stall: got %h expected %h", got, want); end
    step(0, 1, 0, 1, 32'h00221818, 32'h1, 32'h2, bub(0));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL flush_illegal: got %h expected %h", got, want); end
    step(0, 0, 0, 0, 32'h00221820, 32'h1, 32'h2, bub(0));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL no_valid: got %h expected %h", got, want); end
  endtask

  task automatic test_illegal;
    step(0, 1, 0, 0, 32'h00221818, 32'h1, 32'h2, bub(1));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL illegal_funct: got %h expected %h", got, want); end
    step(0, 1, 0, 0, 32'h00221820, 32'h1, 32'h2, ins(4'h0, 1, 2, 0, 3, 1, 0, 0, 0, 0, 2));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL illegal_one_cycle: got %h expected %h", got, want); end
    step(0, 1, 0, 0, 32'hFC000000, 32'h1, 32'h2, bub(1));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL illegal_opcode: got %h expected %h", got, want); end
    step(0, 0, 0, 0, 32'hFC000000, 32'h1, 32'h2, bub(0));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL illegal_not_valid: got %h expected %h", got, want); end
    step(1, 1, 0, 0, 32'hFC000000, 32'h1, 32'h2, bub(0));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL illegal_in_reset: got %h expected %h", got, want); end
  endtask

  task automatic test_reset_mid_stall;
    step(0, 1, 0, 0, 32'h3C05FFFF, 32'h0, 32'h0, ins(4'hF, 0, 32'h0000FFFF, 0, 5, 1, 0, 0, 0, 0, 0));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_stall_load: got %h expected %h", got, want); end
    step(1, 1, 1, 0, 32'h3C05FFFF, 32'h0, 32'h0, bub(0));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_mid_stall: got %h expected %h", got, want); end
    step(1, 1, 1, 1, 32'h3C05FFFF, 32'h0, 32'h0, bub(0));
    got = obs; want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_mid_flush: got %h expected %h", got, want); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rs, rt, instr;
    logic [4:0]  rd;
    for (int i = 0; i < 24; i++) begin
      rs = $urandom; rt = $urandom;
      rd = 5'($urandom_range(1, 31));
      instr = {6'h00, 5'd1, 5'd2, rd, 5'd0, 6'h26};
      step(0, 1, 0, 0, instr, rs, rt, ins(4'h6, rs, rt, 0, rd, 1, 0, 0, 0, 0, rt));
      got = obs; want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_instr = '0; i_rs = '0; i_rt = '0;
    test_reset;
    test_rtype;
    test_itype;
    test_stall;
    test_flush;
    test_illegal;
    test_reset_mid_stall;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
